// File: rtl/instruction_encoder.sv
// RV32 instruction encoder: packs R/I/S/B fields into a word, substitutes a NOP on
// bad input. Ports: valid/ready field input, valid/ready word output with address.
module instruction_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic              out_err,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        err_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        acc;
  logic        take;
  logic        err;
  logic        i_bad;
  logic        b_bad;
  logic [31:0] enc;
  logic [31:0] imm;
  logic        is_r;
  logic        is_ld;
  logic        is_st;
  logic        is_br;
  logic        is_op;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign take     = out_valid && out_ready;
  assign imm      = in_imm;

  assign is_r  = in_fmt == 3'd0;
  assign is_ld = in_fmt == 3'd1;
  assign is_st = in_fmt == 3'd2;
  assign is_br = in_fmt == 3'd3;
  assign is_op = in_fmt == 3'd4;

  // 12-bit signed field range for I/S; 13-bit even range for B
  assign i_bad = ($signed(imm) < -32'sd2048) ||
                 ($signed(imm) > 32'sd2047);
  assign b_bad = ($signed(imm) < -32'sd4096) ||
                 ($signed(imm) > 32'sd4094) ||
                 imm[0];

  always_comb begin
    enc = NOP;
    err = 1'b1;
    unique case (1'b1)
      is_r: begin
        enc = {in_funct7, in_rs2, in_rs1,
               in_funct3, in_rd, 7'b0110011};
        err = 1'b0;
      end
      is_ld: begin
        enc = {imm[11:0], in_rs1, in_funct3,
               in_rd, 7'b0000011};
        err = i_bad;
      end
      is_st: begin
        enc = {imm[11:5], in_rs2, in_rs1,
               in_funct3, imm[4:0], 7'b0100011};
        err = i_bad;
      end
      is_br: begin
        enc = {imm[12], imm[10:5], in_rs2,
               in_rs1, in_funct3, imm[4:1],
               imm[11], 7'b1100011};
        err = b_bad;
      end
      is_op: begin
        enc = {imm[11:0], in_rs1, in_funct3,
               in_rd, 7'b0010011};
        err = i_bad;
      end
      default: begin
        enc = NOP;
        err = 1'b1;
      end
    endcase
    if (err) enc = NOP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      out_addr  <= '0;
      err_cnt   <= '0;
    end else begin
      if (acc) begin
        out_valid <= 1'b1;
        out_instr <= enc;
        out_err   <= err;
      end else if (take) begin
        out_valid <= 1'b0;
      end
      // address belongs to the word leaving, so it moves on consumption
      if (take) out_addr <= out_addr + ADDR_W'(4);
      if (acc && err && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder (ADDR_W=4 so address wrap is reachable).
// Drives one step after each rising edge, checks with immediate assertions.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [3:0]  out_addr;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  instruction_encoder #(.ADDR_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .out_addr(out_addr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic put(input logic [2:0] f,
                     input logic [4:0] rd,
                     input logic [4:0] r1,
                     input logic [4:0] r2,
                     input logic [2:0] f3,
                     input logic [6:0] f7,
                     input logic [31:0] im);
    in_valid  = 1'b1;
    in_fmt    = f;
    in_rd     = rd;
    in_rs1    = r1;
    in_rs2    = r2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = im;
  endtask

  task automatic word(input string tag,
                      input logic [31:0] ins,
                      input logic e,
                      input logic [3:0] a,
                      input logic [7:0] c);
    chk({tag, ".v"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".ins"}, out_instr, ins);
    chk({tag, ".err"}, {31'd0, out_err}, {31'd0, e});
    chk({tag, ".addr"}, {28'd0, out_addr}, {28'd0, a});
    chk({tag, ".cnt"}, {24'd0, err_cnt}, {24'd0, c});
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    put(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid  = 1'b0;
    step();
    chk("rst.v", {31'd0, out_valid}, 32'd0);
    chk("rst.ins", out_instr, 32'd0);
    chk("rst.addr", {28'd0, out_addr}, 32'd0);
    chk("rst.cnt", {24'd0, err_cnt}, 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    chk("idle.rdy", {31'd0, in_ready}, 32'd1);

    put(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    step();
    word("r", 32'h002081B3, 1'b0, 4'd0, 8'd0);
    put(3'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, -32'sd4);
    step();
    word("ld", 32'hFFC12283, 1'b0, 4'd4, 8'd0);
    put(3'd2, 5'd0, 5'd2, 5'd6, 3'd2, 7'd0, 32'd8);
    step();
    word("st", 32'h00612423, 1'b0, 4'd8, 8'd0);
    put(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8);
    step();
    word("br", 32'hFE208CE3, 1'b0, 4'd12, 8'd0);
    put(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    step();
    word("e.imm", 32'h00000013, 1'b1, 4'd0, 8'd1);
    put(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    word("e.odd", 32'h00000013, 1'b1, 4'd4, 8'd2);
    put(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    step();
    word("e.fmt", 32'h00000013, 1'b1, 4'd8, 8'd3);

    out_ready = 1'b0;
    put(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    #1;
    chk("bp.rdy", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      word("bp.hold", 32'h00000013, 1'b1, 4'd8, 8'd3);
      chk("bp.rdy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.rel", {31'd0, in_ready}, 32'd1);
    step();
    word("addi", 32'h00500093, 1'b0, 4'd12, 8'd3);

    put(3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047);
    step();
    word("i.max", 32'h7FF00003, 1'b0, 4'd0, 8'd3);
    put(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
    step();
    word("i.min", 32'h80000013, 1'b0, 4'd4, 8'd3);
    put(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094);
    step();
    word("b.max", 32'h7E000FE3, 1'b0, 4'd8, 8'd3);
    put(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
    step();
    word("b.over", 32'h00000013, 1'b1, 4'd12, 8'd4);
    put(3'd2, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2049);
    step();
    word("s.under", 32'h00000013, 1'b1, 4'd0, 8'd5);
    put(3'd0, 5'd1, 5'd1, 5'd1, 3'd7, 7'h20, 32'hFFFFFFFF);
    step();
    word("r.imm", 32'h4010F0B3, 1'b0, 4'd4, 8'd5);

    in_valid = 1'b0;
    step();
    chk("drain.v", {31'd0, out_valid}, 32'd0);
    chk("drain.addr", {28'd0, out_addr}, 32'd8);
    chk("drain.rdy", {31'd0, in_ready}, 32'd1);

    put(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    for (int i = 0; i < 300; i++) step();
    chk("sat.cnt", {24'd0, err_cnt}, 32'd255);
    chk("sat.err", {31'd0, out_err}, 32'd1);
    chk("sat.v", {31'd0, out_valid}, 32'd1);

    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("mrst.v", {31'd0, out_valid}, 32'd0);
    chk("mrst.ins", out_instr, 32'd0);
    chk("mrst.addr", {28'd0, out_addr}, 32'd0);
    chk("mrst.cnt", {24'd0, err_cnt}, 32'd0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    put(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    step();
    word("post", 32'h002081B3, 1'b0, 4'd0, 8'd0);
    in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
